// File: rtl/layer_argmax_16.sv
// layer_argmax_16: streams M signed activations per vector and emits the max value and its index.
module layer_argmax_16 #(
    parameter int M     = 16,
    parameter int LOGM  = 4,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] data_in,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] data_out,
    output logic [LOGM-1:0]         idx_out,
    output logic [15:0]             vec_count
);
    typedef enum logic [1:0] {INIT, COLLECT, OUTPUT} state_t;
    state_t state;
    logic [LOGM-1:0] cnt, idx_r, nidx;
    logic signed [WIDTH-1:0] max_r, nmax;
    logic take, last;
    // The first element always loads; later ones only on strictly greater, so ties keep the lower index.
    always_comb begin
        take = (cnt == '0) || (data_in > max_r);
        nmax = take ? data_in : max_r;
        nidx = take ? cnt : idx_r;
        last = cnt == LOGM'(M - 1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            data_out  <= '0;
            idx_out   <= '0;
            vec_count <= '0;
            cnt       <= '0;
            max_r     <= '0;
            idx_r     <= '0;
        end else begin
            case (state)
                INIT: begin
                    s_ready <= 1'b1;
                    state   <= COLLECT;
                end
                COLLECT: if (s_valid && s_ready) begin
                    max_r <= nmax;
                    idx_r <= nidx;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        s_ready  <= 1'b0;
                        m_valid  <= 1'b1;
                        data_out <= nmax;
                        idx_out  <= nidx;
                        state    <= OUTPUT;
                    end
                end
                OUTPUT: if (m_ready) begin
                    m_valid   <= 1'b0;
                    s_ready   <= 1'b1;
                    vec_count <= vec_count + 1'b1;
                    state     <= COLLECT;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_argmax_16.sv
// tb_layer_argmax_16: randomized scoreboard bench comparing results against a reference argmax model.
module tb_layer_argmax_16;
    typedef logic signed [15:0] vec_t [16];
    typedef struct { logic signed [15:0] val; logic [3:0] idx; } res_t;

    logic clk = 0, reset = 1, s_valid = 0, m_ready = 0;
    logic signed [15:0] data_in = 0;
    logic s_ready, m_valid;
    logic signed [15:0] data_out;
    logic [3:0] idx_out;
    logic [15:0] vec_count;

    int checks = 0, failures = 0, beats = 0, nvec = 0, stalls = 0;
    bit seen = 0;
    res_t sb[$];

    layer_argmax_16 dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
        .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out), .idx_out(idx_out),
        .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) if (!reset && s_valid && s_ready) beats++;

    // Monitor: compare each newly presented result against the oldest expected one.
    always @(negedge clk) begin
        if (!reset) check("no_overlap", s_ready && m_valid, 0);
        if (!m_valid) seen = 0;
        else if (!seen) begin
            seen = 1;
            if (sb.size() == 0) check("unexpected_result", 1, 0);
            else begin
                res_t e;
                e = sb.pop_front();
                check("data_out", data_out, e.val);
                check("idx_out", idx_out, e.idx);
            end
        end
    end

    function automatic res_t ref_argmax(input vec_t v);
        res_t r;
        r.val = v[0];
        r.idx = 0;
        for (int i = 1; i < 16; i++)
            if (v[i] > r.val) begin r.val = v[i]; r.idx = 4'(i); end
        return r;
    endfunction

    // Drives the first n elements of v; only a complete vector produces an expected result.
    task automatic send(input vec_t v, input int n, input bit gaps);
        int b0, t;
        b0 = beats;
        stalls = 0;
        if (n == 16) sb.push_back(ref_argmax(v));
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom % 2) begin @(negedge clk); s_valid = 0; end
            @(negedge clk);
            s_valid = 1;
            data_in = v[i];
            t = 0;
            while (!s_ready && t < 200) begin @(negedge clk); t++; stalls++; end
            if (t >= 200) check("send_timeout", t, 0);
        end
        @(negedge clk);
        s_valid = 0;
        check("beats_consumed", beats - b0, n);
        if (n == 16) check("latency_m_valid", m_valid, 1);
    endtask

    task automatic finish_vec(input bit rnd);
        int t = 0;
        m_ready = rnd ? 1'($urandom % 2) : 1'b1;
        while (!(m_valid && m_ready) && t < 500) begin
            @(negedge clk);
            m_ready = rnd ? 1'($urandom % 2) : 1'b1;
            t++;
        end
        if (t >= 500) check("result_timeout", t, 0);
        @(negedge clk);
        m_ready = 0;
        nvec++;
        check("vec_count", vec_count, nvec);
        check("s_ready_after_hs", s_ready, 1);
        check("m_valid_after_hs", m_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        s_valid = 0;
        m_ready = 0;
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_idx_out", idx_out, 0);
        check("rst_vec_count", vec_count, 0);
        reset = 0;
        nvec = 0;
        sb.delete();
    endtask

    initial begin
        vec_t v;
        logic signed [15:0] hd;
        logic [3:0] hi;
        int b0;
        do_reset();

        for (int i = 0; i < 16; i++) v[i] = 16'(i);
        m_ready = 1;
        send(v, 16, 0);
        check("no_stall_ramp", stalls, 0);
        finish_vec(0);

        v[0] = 5; v[1] = 9; v[2] = 9;
        for (int i = 3; i < 16; i++) v[i] = 2;
        send(v, 16, 0);
        finish_vec(0);

        for (int i = 0; i < 16; i++) v[i] = -3;
        v[7] = -1;
        send(v, 16, 1);
        finish_vec(1);

        for (int i = 0; i < 16; i++) v[i] = -32768;
        send(v, 16, 0);
        finish_vec(1);

        v[0] = 100;
        for (int i = 1; i < 16; i++) v[i] = 16'($signed($urandom_range(0, 299)) - 200);
        send(v, 16, 1);
        finish_vec(1);

        // Hold the result for 10 cycles with upstream pushing.
        for (int i = 0; i < 16; i++) v[i] = 16'($urandom);
        send(v, 16, 1);
        hd = data_out;
        hi = idx_out;
        b0 = beats;
        s_valid = 1;
        data_in = 16'h7fff;
        repeat (10) begin
            @(negedge clk);
            check("hold_m_valid", m_valid, 1);
            check("hold_s_ready", s_ready, 0);
            check("hold_data", data_out, hd);
            check("hold_idx", idx_out, hi);
        end
        check("hold_no_consume", beats - b0, 0);
        s_valid = 0;
        finish_vec(0);

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 16; i++)
                v[i] = (k % 2) ? 16'($signed($urandom_range(0, 7)) - 4) : 16'($urandom);
            send(v, 16, 1);
            finish_vec(1);
        end

        for (int i = 0; i < 16; i++) v[i] = 16'($urandom);
        send(v, 6, 1);
        do_reset();
        for (int i = 0; i < 16; i++) v[i] = 16'($signed($urandom_range(0, 80)) - 40);
        v[3] = 42;
        for (int i = 4; i < 16; i++) if (v[i] >= 42) v[i] = 41;
        send(v, 16, 1);
        finish_vec(1);
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/layer_argmax_16.md
Name: layer_argmax_16

Overview:
- Classifier stage directly downstream of the last MVM layer.
- Consumes the layer's serial output stream, M signed 16-bit activations per vector, through a valid/ready handshake.
- Emits one beat per vector: the maximum value and its index. Also keeps a running count of vectors classified.
- Sits between the final layer's data_out/m_valid/m_ready and the system result port.

Parameters:
- M, 16, elements per input vector (final layer output count); M >= 2.
- LOGM, 4, width of the index output; 2^LOGM >= M.
- WIDTH, 16, data width of input and max value.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_valid  input  1  upstream data valid.
- s_ready  output  1  block can accept a beat.
- data_in  input  WIDTH  signed activation, element order 0..M-1.
- m_valid  output  1  result valid.
- m_ready  input  1  downstream accepts result.
- data_out  output  WIDTH  signed maximum value of the vector.
- idx_out  output  LOGM  index of the maximum element.
- vec_count  output  16  number of results accepted downstream since reset.

Behaviour:
- Reset values (cycle after reset is sampled high):
  - s_ready=0, m_valid=0, data_out=0, idx_out=0, vec_count=0.
  - Element counter=0, state=Init.
- Reset overrides everything. Reset mid-vector discards the partial vector. Reset while m_valid=1 drops the pending result with no handshake.
- Registers: element counter cnt[LOGM-1:0], running max max_r, running index idx_r. All outputs are registered; no combinational path from any input to any output.
- State Init (one cycle): s_ready<=1, go to Collect.
- State Collect:
  - A beat is accepted only when s_valid && s_ready. If s_valid=1 and s_ready=0, nothing is consumed.
  - Accepted beat with cnt==0: max_r<=data_in, idx_r<=0, unconditionally.
  - Accepted beat with cnt>0: if data_in > max_r (signed, strict), max_r<=data_in and idx_r<=cnt. Otherwise hold.
  - Ties keep the lower index.
  - Accepted beat with cnt==M-1:
    - The comparison on this beat is included in the result.
    - s_ready<=0, m_valid<=1, cnt<=0, go to Output.
    - data_out/idx_out take the final max/index in that same edge.
  - Otherwise cnt<=cnt+1 on each accepted beat. cnt holds while no beat is accepted, so gaps in s_valid are allowed anywhere in the vector.
- Latency: m_valid rises on the clock edge that accepts element M-1, i.e. it is visible the cycle after the last input handshake.
- State Output:
  - While m_valid=1 and m_ready=0: data_out, idx_out and m_valid hold stable; s_ready stays 0.
  - On m_ready=1: m_valid<=0, s_ready<=1, vec_count<=vec_count+1 (wraps 65535->0), go to Collect.
  - One bubble cycle then separates consecutive vectors.
  - data_out/idx_out keep their last values after the handshake until the next result is loaded.
- m_ready while m_valid=0 is ignored.
- Signed arithmetic throughout. Negative inputs are legal; an all-negative vector returns its least-negative element. Most negative value is -32768.
- No simultaneous accept-and-emit: s_ready and m_valid are never both 1.

Test Plan:
- Reset, then feed 0,1,...,15 with s_valid held high -> s_ready=1 for 16 consecutive cycles; next cycle m_valid=1, data_out=15, idx_out=15; with m_ready=1: vec_count=1, s_ready=1 one cycle later.
- Feed 5,9,9,2,...,2 (9 at indices 1 and 2) -> data_out=9, idx_out=1 (tie keeps lower index).
- Feed all elements -3 except index 7 = -1 -> data_out=-1, idx_out=7. Feed all -32768 -> data_out=-32768, idx_out=0.
- Random s_valid gaps (about 50% duty) with first element 100 at index 0 -> exactly 16 beats consumed; result data_out=100, idx_out=0; no beat lost or duplicated.
- Hold m_ready=0 for 10 cycles after m_valid -> outputs stable, s_ready=0, s_valid beats not consumed; then m_ready=1 -> one handshake, vec_count increments once.
- Assert reset after 6 accepted beats, then feed a full new vector whose max is 42 at index 3 -> result data_out=42, idx_out=3, vec_count=1 (partial vector discarded).
